// File: rtl/sdram_axi_pkg.sv
// Shared AXI constants and FSM encoding for the SDRAM traffic generator.
package sdram_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B   = 3'd1;   // 2 bytes per beat
  localparam logic [1:0] AXI_STRB_FULL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR_AW,
    ST_WR_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_DONE
  } tg_state_e;

endpackage

// File: rtl/sdram_axi_traffic_gen_if.sv
// 16-bit AXI4 bundle between the traffic generator (master) and SdramController (slave).
interface sdram_axi_traffic_gen_if;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_payload_addr;
  logic [3:0]  aw_payload_id;
  logic [7:0]  aw_payload_len;
  logic [2:0]  aw_payload_size;
  logic [1:0]  aw_payload_burst;

  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_payload_data;
  logic [1:0]  w_payload_strb;
  logic        w_payload_last;

  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_payload_id;
  logic [1:0]  b_payload_resp;

  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_payload_addr;
  logic [3:0]  ar_payload_id;
  logic [7:0]  ar_payload_len;
  logic [2:0]  ar_payload_size;
  logic [1:0]  ar_payload_burst;

  logic        r_valid;
  logic        r_ready;
  logic [15:0] r_payload_data;
  logic [3:0]  r_payload_id;
  logic [1:0]  r_payload_resp;
  logic        r_payload_last;

  modport master (
    output aw_valid, aw_payload_addr, aw_payload_id, aw_payload_len, aw_payload_size, aw_payload_burst,
    input  aw_ready,
    output w_valid, w_payload_data, w_payload_strb, w_payload_last,
    input  w_ready,
    input  b_valid, b_payload_id, b_payload_resp,
    output b_ready,
    output ar_valid, ar_payload_addr, ar_payload_id, ar_payload_len, ar_payload_size, ar_payload_burst,
    input  ar_ready,
    input  r_valid, r_payload_data, r_payload_id, r_payload_resp, r_payload_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_payload_addr, aw_payload_id, aw_payload_len, aw_payload_size, aw_payload_burst,
    output aw_ready,
    input  w_valid, w_payload_data, w_payload_strb, w_payload_last,
    output w_ready,
    output b_valid, b_payload_id, b_payload_resp,
    input  b_ready,
    input  ar_valid, ar_payload_addr, ar_payload_id, ar_payload_len, ar_payload_size, ar_payload_burst,
    output ar_ready,
    output r_valid, r_payload_data, r_payload_id, r_payload_resp, r_payload_last,
    input  r_ready
  );
endinterface

// File: rtl/sdram_pattern_gen.sv
// Beat index -> test data. Used for both the write data and the read-back compare.
module sdram_pattern_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic [23:0] beat_idx,
  output logic [15:0] data
);
  // Upper index bits fold into the high byte so patterns do not repeat every 64K beats.
  assign data = beat_idx[15:0] ^ SEED ^ {beat_idx[23:16], 8'h00};
endmodule

// File: rtl/sdram_axi_traffic_gen.sv
// Write/read-back self-test master for the SDRAM AXI4 slave port.
module sdram_axi_traffic_gen
  import sdram_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_BURSTS = 16,
  parameter logic [3:0]  AXI_ID     = 4'h3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic                    io_initDone,
  sdram_axi_traffic_gen_if.master io_axi,
  output logic                    io_busy,
  output logic                    io_done,
  output logic                    io_pass,
  output logic [15:0]             io_errorCount,
  output logic [31:0]             io_firstErrAddr
);

  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);

  tg_state_e   state_q, state_d;
  logic [15:0] burst_idx_q, burst_idx_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] first_err_q, first_err_d;

  logic [31:0] burst_off, burst_addr, beat_addr;
  logic [23:0] beat_idx;
  logic [15:0] pat_data;
  logic        last_beat, last_burst, start_acc;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        b_err, r_err, err_hit;
  logic [31:0] err_addr;

  // Address / index arithmetic; burst_off < 2^24 for all legal parameters.
  assign burst_off  = 32'(burst_idx_q) * 32'(BURST_LEN);
  assign burst_addr = ADDR_BASE + (burst_off << 1);
  assign beat_addr  = burst_addr + {23'd0, beat_q, 1'b0};
  assign beat_idx   = burst_off[23:0] + {16'd0, beat_q};

  sdram_pattern_gen #(.SEED(SEED)) u_pat (
    .beat_idx (beat_idx),
    .data     (pat_data)
  );

  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_burst = (burst_idx_q == LAST_BURST);
  assign start_acc  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && io_start;

  // Handshakes qualified by state: our valids/readys are pure functions of state.
  assign aw_hs = (state_q == ST_WR_AW) && io_axi.aw_ready;
  assign w_hs  = (state_q == ST_WR_W)  && io_axi.w_ready;
  assign b_hs  = (state_q == ST_WR_B)  && io_axi.b_valid;
  assign ar_hs = (state_q == ST_RD_AR) && io_axi.ar_ready;
  assign r_hs  = (state_q == ST_RD_R)  && io_axi.r_valid;

  // A beat contributes at most one error no matter how many fields are wrong.
  assign b_err = b_hs && ((io_axi.b_payload_resp != AXI_RESP_OKAY) ||
                          (io_axi.b_payload_id != AXI_ID));
  assign r_err = r_hs && ((io_axi.r_payload_data != pat_data) ||
                          (io_axi.r_payload_resp != AXI_RESP_OKAY) ||
                          (io_axi.r_payload_id != AXI_ID) ||
                          (io_axi.r_payload_last != last_beat));
  assign err_hit  = b_err || r_err;
  assign err_addr = (state_q == ST_WR_B) ? burst_addr : beat_addr;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_idx_q <= '0;
      beat_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (io_start)    state_d = ST_WAIT_INIT;
      ST_WAIT_INIT:     if (io_initDone) state_d = ST_WR_AW;
      ST_WR_AW:         if (aw_hs)       state_d = ST_WR_W;
      ST_WR_W:          if (w_hs && last_beat) state_d = ST_WR_B;
      ST_WR_B:          if (b_hs)  state_d = last_burst ? ST_RD_AR : ST_WR_AW;
      ST_RD_AR:         if (ar_hs)       state_d = ST_RD_R;
      ST_RD_R:          if (r_hs && last_beat) state_d = last_burst ? ST_DONE : ST_RD_AR;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Beat/burst counters and error bookkeeping.
  always_comb begin
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (start_acc) begin
      burst_idx_d = '0;
      beat_d      = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
    end else begin
      if (w_hs || r_hs)
        beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
      if (b_hs || (r_hs && last_beat))
        burst_idx_d = last_burst ? 16'd0 : burst_idx_q + 16'd1;
      if (err_hit) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        // A zero count means nothing has failed yet in this pass.
        if (err_cnt_q == 16'd0) first_err_d = err_addr;
      end
    end
  end

  // Bus and status outputs, decoded from state only.
  always_comb begin
    io_axi.aw_valid         = (state_q == ST_WR_AW);
    io_axi.aw_payload_addr  = burst_addr;
    io_axi.aw_payload_id    = AXI_ID;
    io_axi.aw_payload_len   = LAST_BEAT;
    io_axi.aw_payload_size  = AXI_SIZE_16B;
    io_axi.aw_payload_burst = AXI_BURST_INCR;

    io_axi.w_valid          = (state_q == ST_WR_W);
    io_axi.w_payload_data   = pat_data;
    io_axi.w_payload_strb   = AXI_STRB_FULL;
    io_axi.w_payload_last   = (state_q == ST_WR_W) && last_beat;

    io_axi.b_ready          = (state_q == ST_WR_B);

    io_axi.ar_valid         = (state_q == ST_RD_AR);
    io_axi.ar_payload_addr  = burst_addr;
    io_axi.ar_payload_id    = AXI_ID;
    io_axi.ar_payload_len   = LAST_BEAT;
    io_axi.ar_payload_size  = AXI_SIZE_16B;
    io_axi.ar_payload_burst = AXI_BURST_INCR;

    io_axi.r_ready          = (state_q == ST_RD_R);

    io_busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    io_done         = (state_q == ST_DONE);
    io_pass         = (state_q == ST_DONE) && (err_cnt_q == 16'd0);
    io_errorCount   = err_cnt_q;
    io_firstErrAddr = first_err_q;
  end

endmodule

// File: tb/tb_sdram_axi_traffic_gen.sv
// Self-checking bench: reactive memory-echo AXI slave with fault injection and stalls.
module tb_sdram_axi_traffic_gen;
  localparam int          BL  = 8;
  localparam int          NB  = 16;
  localparam logic [3:0]  ID  = 4'h3;
  localparam logic [15:0] SD  = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset, io_start, io_initDone;
  logic        io_busy, io_done, io_pass;
  logic [15:0] io_errorCount;
  logic [31:0] io_firstErrAddr;

  sdram_axi_traffic_gen_if axi();

  sdram_axi_traffic_gen #(
    .ADDR_BASE(32'h0), .BURST_LEN(BL), .NUM_BURSTS(NB), .AXI_ID(ID), .SEED(SD)
  ) dut (
    .clk(clk), .reset(reset), .io_start(io_start), .io_initDone(io_initDone),
    .io_axi(axi), .io_busy(io_busy), .io_done(io_done), .io_pass(io_pass),
    .io_errorCount(io_errorCount), .io_firstErrAddr(io_firstErrAddr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fault-injection knobs (written by the test sequence only).
  int corrupt_burst = -1, corrupt_beat = -1, b_err_burst = -1, r_err_burst = -1;
  bit stall_en = 0;

  // Slave-side observations (written by the slave process only).
  int          aw_cnt, ar_cnt, w_total, viol;
  logic [15:0] first_w [2];
  logic [15:0] mem [int];

  function automatic bit go();
    return !stall_en || ($urandom_range(99) >= 30);
  endfunction

  function automatic logic [15:0] pattern(input int g);
    logic [23:0] gg;
    gg = g[23:0];
    return gg[15:0] ^ SD ^ {gg[23:16], 8'h00};
  endfunction

  // Expected error count / first address, walking the pass beat by beat.
  task automatic model(output int cnt, output logic [31:0] first);
    cnt = 0; first = 32'h0;
    for (int b = 0; b < NB; b++)
      if (b == b_err_burst) begin
        if (cnt == 0) first = 32'(b * BL * 2);
        cnt++;
      end
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < BL; k++)
        if ((b == corrupt_burst && k == corrupt_beat) || b == r_err_burst) begin
          if (cnt == 0) first = 32'((b * BL + k) * 2);
          cnt++;
        end
    if (cnt > 65535) cnt = 65535;
  endtask

  // Reactive slave: everything is decided at the falling edge, handshakes happen at the next rising edge.
  initial begin : slave
    logic [31:0] wq_addr [$];
    int          b_q [$];
    logic [31:0] rq_addr [$];
    int          rq_burst [$];
    int          wbeat, rbeat, key;
    bit          b_fire, r_fire, prev_busy, p_aw, p_w, p_ar;
    logic [31:0] p_aw_addr, p_ar_addr;
    logic [15:0] p_w_data, d;
    logic        p_w_last;
    wbeat = 0; rbeat = 0; b_fire = 0; r_fire = 0; prev_busy = 0;
    p_aw = 0; p_w = 0; p_ar = 0; p_aw_addr = '0; p_ar_addr = '0; p_w_data = '0; p_w_last = 0;
    aw_cnt = 0; ar_cnt = 0; w_total = 0; viol = 0;
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_payload_id = 0; axi.b_payload_resp = 0;
    axi.r_valid = 0; axi.r_payload_data = 0; axi.r_payload_id = 0;
    axi.r_payload_resp = 0; axi.r_payload_last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wq_addr.delete(); b_q.delete(); rq_addr.delete(); rq_burst.delete(); mem.delete();
        wbeat = 0; rbeat = 0; b_fire = 0; r_fire = 0; prev_busy = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
        aw_cnt = 0; ar_cnt = 0; w_total = 0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
        axi.b_valid = 0; axi.r_valid = 0;
        continue;
      end
      if (io_busy && !prev_busy) begin
        aw_cnt = 0; ar_cnt = 0; w_total = 0; viol = 0;
      end
      prev_busy = io_busy;
      // Master must hold valid and payload while a handshake is pending.
      if (p_aw && (axi.aw_valid !== 1'b1 || axi.aw_payload_addr !== p_aw_addr)) viol++;
      if (p_w && (axi.w_valid !== 1'b1 || axi.w_payload_data !== p_w_data ||
                  axi.w_payload_last !== p_w_last)) viol++;
      if (p_ar && (axi.ar_valid !== 1'b1 || axi.ar_payload_addr !== p_ar_addr)) viol++;
      if (b_fire) axi.b_valid = 0;
      if (r_fire) axi.r_valid = 0;
      axi.aw_ready = go();
      axi.w_ready  = go();
      axi.ar_ready = go();
      if (!axi.b_valid && b_q.size() > 0 && go()) begin
        axi.b_valid = 1; axi.b_payload_id = ID;
        axi.b_payload_resp = (b_q[0] == b_err_burst) ? 2'b10 : 2'b00;
      end
      if (!axi.r_valid && rq_addr.size() > 0 && go()) begin
        key = int'(rq_addr[0] >> 1) + rbeat;
        d = mem.exists(key) ? mem[key] : 16'h0;
        if (rq_burst[0] == corrupt_burst && rbeat == corrupt_beat) d = d ^ 16'h0001;
        axi.r_valid = 1; axi.r_payload_data = d; axi.r_payload_id = ID;
        axi.r_payload_resp = (rq_burst[0] == r_err_burst) ? 2'b10 : 2'b00;
        axi.r_payload_last = (rbeat == BL - 1);
      end
      // Handshakes that will occur at the coming rising edge.
      if (axi.aw_valid && axi.aw_ready) begin
        if (axi.aw_payload_addr !== 32'(aw_cnt * BL * 2) || axi.aw_payload_id !== ID ||
            axi.aw_payload_len !== 8'(BL - 1) || axi.aw_payload_size !== 3'd1 ||
            axi.aw_payload_burst !== 2'b01) viol++;
        wq_addr.push_back(axi.aw_payload_addr);
        aw_cnt++;
      end
      if (axi.w_valid && axi.w_ready) begin
        if (wq_addr.size() == 0 || axi.w_payload_strb !== 2'b11 ||
            axi.w_payload_last !== (wbeat == BL - 1)) viol++;
        if (wq_addr.size() > 0) begin
          mem[int'(wq_addr[0] >> 1) + wbeat] = axi.w_payload_data;
          if (w_total < 2) first_w[w_total] = axi.w_payload_data;
          w_total++;
          wbeat++;
          if (wbeat == BL) begin
            wbeat = 0; void'(wq_addr.pop_front()); b_q.push_back(aw_cnt - 1);
          end
        end
      end
      b_fire = axi.b_valid && axi.b_ready;
      if (b_fire) void'(b_q.pop_front());
      if (axi.ar_valid && axi.ar_ready) begin
        if (axi.ar_payload_addr !== 32'(ar_cnt * BL * 2) || axi.ar_payload_id !== ID ||
            axi.ar_payload_len !== 8'(BL - 1) || axi.ar_payload_size !== 3'd1 ||
            axi.ar_payload_burst !== 2'b01) viol++;
        rq_addr.push_back(axi.ar_payload_addr); rq_burst.push_back(ar_cnt);
        ar_cnt++;
      end
      r_fire = axi.r_valid && axi.r_ready;
      if (r_fire) begin
        rbeat++;
        if (rbeat == BL) begin
          rbeat = 0; void'(rq_addr.pop_front()); void'(rq_burst.pop_front());
        end
      end
      p_aw = axi.aw_valid && !axi.aw_ready; p_aw_addr = axi.aw_payload_addr;
      p_w  = axi.w_valid && !axi.w_ready;   p_w_data = axi.w_payload_data; p_w_last = axi.w_payload_last;
      p_ar = axi.ar_valid && !axi.ar_ready; p_ar_addr = axi.ar_payload_addr;
    end
  end

  task automatic start_and_wait(input string name);
    @(negedge clk); io_start = 1;
    @(negedge clk); io_start = 0;
    checks++;
    if (io_busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start: got %b expected 1", name, io_busy); end
    for (int i = 0; i < 20000 && io_done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (io_done !== 1'b1) begin failures++; $display("FAIL %s done_timeout: got %b expected 1", name, io_done); end
  endtask

  task automatic check_result(input string name);
    int exp_cnt; logic [31:0] exp_first;
    model(exp_cnt, exp_first);
    checks++;
    if (io_errorCount !== 16'(exp_cnt)) begin failures++; $display("FAIL %s error_count: got %0d expected %0d", name, io_errorCount, exp_cnt); end
    checks++;
    if (io_firstErrAddr !== exp_first) begin failures++; $display("FAIL %s first_err_addr: got %h expected %h", name, io_firstErrAddr, exp_first); end
    checks++;
    if (io_pass !== (exp_cnt == 0)) begin failures++; $display("FAIL %s pass: got %b expected %b", name, io_pass, exp_cnt == 0); end
    checks++;
    if (aw_cnt != NB || ar_cnt != NB) begin failures++; $display("FAIL %s burst_counts: got aw=%0d ar=%0d expected %0d", name, aw_cnt, ar_cnt, NB); end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL %s protocol: got %0d violations expected 0", name, viol); end
  endtask

  task automatic clear_faults();
    corrupt_burst = -1; corrupt_beat = -1; b_err_burst = -1; r_err_burst = -1; stall_en = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({axi.aw_valid, axi.w_valid, axi.w_payload_last, axi.b_ready, axi.ar_valid, axi.r_ready,
         io_busy, io_done, io_pass} !== 9'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 0",
        {axi.aw_valid, axi.w_valid, axi.w_payload_last, axi.b_ready, axi.ar_valid, axi.r_ready, io_busy, io_done, io_pass});
    end
    checks++;
    if (io_errorCount !== 16'h0 || io_firstErrAddr !== 32'h0) begin
      failures++; $display("FAIL reset_errs: got %h/%h expected 0/0", io_errorCount, io_firstErrAddr);
    end
    checks++;
    if (axi.aw_payload_size !== 3'd1 || axi.aw_payload_burst !== 2'b01 || axi.w_payload_strb !== 2'b11 ||
        axi.ar_payload_size !== 3'd1 || axi.ar_payload_burst !== 2'b01) begin
      failures++; $display("FAIL reset_consts: got size=%0d burst=%b strb=%b", axi.aw_payload_size, axi.aw_payload_burst, axi.w_payload_strb);
    end
  endtask

  task automatic test_ideal();
    int bad;
    clear_faults();
    start_and_wait("ideal");
    check_result("ideal");
    checks++;
    if (first_w[0] !== 16'hACE1 || first_w[1] !== 16'hACE0) begin
      failures++; $display("FAIL ideal_first_w: got %h %h expected ace1 ace0", first_w[0], first_w[1]);
    end
    bad = 0;
    for (int g = 0; g < NB * BL; g++) if (!mem.exists(g) || mem[g] !== pattern(g)) bad++;
    checks++;
    if (bad != 0 || w_total != NB * BL) begin
      failures++; $display("FAIL ideal_mem: got %0d bad words, %0d beats expected 0, %0d", bad, w_total, NB * BL);
    end
  endtask

  task automatic test_corrupt();
    clear_faults(); corrupt_burst = 2; corrupt_beat = 5;
    start_and_wait("corrupt");
    check_result("corrupt");
  endtask

  task automatic test_stall();
    clear_faults(); stall_en = 1;
    start_and_wait("stall");
    check_result("stall");
    stall_en = 0;
  endtask

  task automatic test_resp_err();
    clear_faults(); b_err_burst = 0; r_err_burst = 1;
    start_and_wait("resp_err");
    check_result("resp_err");
    clear_faults();
  endtask

  task automatic test_random_corrupt();
    clear_faults(); stall_en = 1;
    corrupt_burst = $urandom_range(NB - 1); corrupt_beat = $urandom_range(BL - 1);
    start_and_wait("rand_corrupt");
    check_result("rand_corrupt");
    clear_faults();
  endtask

  task automatic test_init_delay();
    int bad, seen;
    clear_faults();
    io_initDone = 0;
    @(negedge clk); io_start = 1;
    @(negedge clk); io_start = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (axi.aw_valid !== 1'b0 || io_busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL init_hold: got %0d bad cycles expected 0", bad); end
    io_initDone = 1;
    checks++;
    if (axi.aw_valid !== 1'b0) begin failures++; $display("FAIL init_early_aw: got %b expected 0", axi.aw_valid); end
    seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (axi.aw_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL init_aw_late: got no aw_valid expected within 2 cycles"); end
    for (int i = 0; i < 20000 && io_done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (io_done !== 1'b1) begin failures++; $display("FAIL init_done_timeout: got %b expected 1", io_done); end
    check_result("init_delay");
  endtask

  task automatic test_reset_mid();
    int waited;
    clear_faults();
    @(negedge clk); io_start = 1;
    @(negedge clk); io_start = 0;
    waited = 0;
    while (aw_cnt < 4 && waited < 5000) begin @(negedge clk); waited++; end
    checks++;
    if (aw_cnt < 4) begin failures++; $display("FAIL rst_mid_reach: got aw=%0d expected >=4", aw_cnt); end
    #2 reset = 1;
    #1;
    checks++;
    if ({axi.aw_valid, axi.w_valid, axi.w_payload_last, axi.b_ready, axi.ar_valid, axi.r_ready,
         io_busy, io_done, io_pass} !== 9'b0 || io_errorCount !== 16'h0 || io_firstErrAddr !== 32'h0) begin
      failures++; $display("FAIL rst_mid_async: got busy=%b awv=%b wv=%b errs=%h expected all 0",
        io_busy, axi.aw_valid, axi.w_valid, io_errorCount);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    start_and_wait("after_reset");
    check_result("after_reset");
  endtask

  initial begin
    reset = 1; io_start = 0; io_initDone = 1;
    #2;
    test_reset();
    @(negedge clk); reset = 0;
    test_ideal();
    test_corrupt();
    test_stall();
    test_resp_err();
    test_random_corrupt();
    test_init_delay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
